// File: rtl/snake_engine_if.sv
// rtl/snake_engine_if.sv - raster coordinates, button pulses and colour selects of snake_engine
interface snake_engine_if #(
    parameter int MAX_LEN = 16
);
    localparam int LW = $clog2(MAX_LEN) + 1;

    logic [9:0]    pixel_x;
    logic [9:0]    pixel_y;
    logic          btn_up;
    logic          btn_down;
    logic          btn_left;
    logic          btn_right;
    logic          btn_start;
    logic          Snake;
    logic          Black;
    logic [LW-1:0] length;

    modport master (
        output pixel_x, pixel_y, btn_up, btn_down, btn_left, btn_right, btn_start,
        input  Snake, Black, length
    );

    modport slave (
        input  pixel_x, pixel_y, btn_up, btn_down, btn_left, btn_right, btn_start,
        output Snake, Black, length
    );
endinterface

// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - snake body ring buffer, move/grow/collision logic and per-pixel body lookup
module snake_engine #(
    parameter int MAX_LEN    = 16,
    parameter int MOVE_DIV   = 2500000,
    parameter int GROW_EVERY = 8
) (
    input  logic          clk25MHz,
    input  logic          reset_n,
    snake_engine_if.slave bus
);
    localparam int PW = $clog2(MAX_LEN);
    localparam int LW = PW + 1;
    localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int GW = (GROW_EVERY > 1) ? $clog2(GROW_EVERY) : 1;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

    state_t state, state_nx;

    logic [5:0]        body_x [MAX_LEN];
    logic [4:0]        body_y [MAX_LEN];
    logic [PW-1:0]     head_ptr;
    logic [LW-1:0]     len;
    logic [1:0]        dir;
    logic [1:0]        last_dir;
    logic [CW-1:0]     tick_cnt;
    logic [GW-1:0]     grow_cnt;
    logic              move_pending;
    logic              snake_q;
    logic              black_q;

    logic              press_any;
    logic [1:0]        press_dir;
    logic signed [6:0] nx;
    logic signed [5:0] ny;
    logic              wall;
    logic              self_hit;
    logic              grow;
    logic              visible;
    logic              on_body;

    logic              accept;
    logic              wrap;
    logic              exec;
    logic              collide;
    logic              advance;
    logic              reinit;

    // Buttons are priority-encoded; opposite codes differ only in bit 0.
    always_comb begin
        press_any = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
        press_dir = DIR_RIGHT;
        if (bus.btn_up)
            press_dir = DIR_UP;
        else if (bus.btn_down)
            press_dir = DIR_DOWN;
        else if (bus.btn_left)
            press_dir = DIR_LEFT;
    end

    always_comb begin
        nx = signed'({1'b0, body_x[head_ptr]});
        ny = signed'({1'b0, body_y[head_ptr]});
        case (dir)
            DIR_UP:   ny = ny - 6'sd1;
            DIR_DOWN: ny = ny + 6'sd1;
            DIR_LEFT: nx = nx - 7'sd1;
            default:  nx = nx + 7'sd1;
        endcase
        wall = (nx < 7'sd0) || (nx > 7'sd39) || (ny < 6'sd0) || (ny > 6'sd29);
    end

    assign grow = (grow_cnt == GW'(GROW_EVERY - 1)) && (len < LW'(MAX_LEN));

    // The tail only counts as an obstacle when it will not vacate its cell.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (((LW'(i) < len - LW'(1)) || (grow && (LW'(i) < len))) &&
                body_x[head_ptr - PW'(i)] == nx[5:0] &&
                body_y[head_ptr - PW'(i)] == ny[4:0])
                self_hit = 1'b1;
        end
    end

    assign visible = (bus.pixel_x < 10'd640) && (bus.pixel_y < 10'd480);

    always_comb begin
        on_body = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LW'(i) < len) &&
                body_x[head_ptr - PW'(i)] == bus.pixel_x[9:4] &&
                body_y[head_ptr - PW'(i)] == bus.pixel_y[8:4])
                on_body = 1'b1;
        end
    end

    always_ff @(posedge clk25MHz or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept)        state_nx = S_RUN;
            S_RUN:   if (collide)       state_nx = S_OVER;
            S_OVER:  if (bus.btn_start) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Moves only execute during vertical blanking so a frame never shows a half-updated body.
    always_comb begin
        accept  = press_any && (state != S_OVER) && (press_dir != (last_dir ^ 2'b01));
        wrap    = (state == S_RUN) && (tick_cnt == CW'(MOVE_DIV - 1));
        exec    = (state == S_RUN) && move_pending && (bus.pixel_y >= 10'd480);
        collide = exec && (wall || self_hit);
        advance = exec && !(wall || self_hit);
        reinit  = (state == S_OVER) && bus.btn_start;
    end

    always_ff @(posedge clk25MHz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                body_x[i] <= (i < 4) ? 6'(17 + i) : 6'd0;
                body_y[i] <= 5'd15;
            end
            head_ptr     <= PW'(3);
            len          <= LW'(4);
            dir          <= DIR_RIGHT;
            last_dir     <= DIR_RIGHT;
            tick_cnt     <= '0;
            grow_cnt     <= '0;
            move_pending <= 1'b0;
            snake_q      <= 1'b0;
            black_q      <= 1'b0;
        end else begin
            snake_q <= visible && on_body;
            black_q <= (state_nx == S_OVER);
            if (reinit) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    body_x[i] <= (i < 4) ? 6'(17 + i) : 6'd0;
                    body_y[i] <= 5'd15;
                end
                head_ptr     <= PW'(3);
                len          <= LW'(4);
                dir          <= DIR_RIGHT;
                last_dir     <= DIR_RIGHT;
                tick_cnt     <= '0;
                grow_cnt     <= '0;
                move_pending <= 1'b0;
            end else begin
                if (accept)
                    dir <= press_dir;
                if (state == S_RUN)
                    tick_cnt <= wrap ? '0 : tick_cnt + CW'(1);
                // A wrap outranks the clear so a tick landing on an execute cycle is not lost.
                if (wrap)
                    move_pending <= 1'b1;
                else if (exec)
                    move_pending <= 1'b0;
                if (advance) begin
                    head_ptr                  <= head_ptr + PW'(1);
                    body_x[head_ptr + PW'(1)] <= nx[5:0];
                    body_y[head_ptr + PW'(1)] <= ny[4:0];
                    last_dir                  <= dir;
                    grow_cnt                  <= (grow_cnt == GW'(GROW_EVERY - 1)) ? '0 : grow_cnt + GW'(1);
                    if (grow)
                        len <= len + LW'(1);
                end
            end
        end
    end

    assign bus.Snake  = snake_q;
    assign bus.Black  = black_q;
    assign bus.length = len;
endmodule

// File: tb/tb_snake_engine.sv
// tb/tb_snake_engine.sv - directed bench for snake_engine, two instances with different grow rates
module tb_snake_engine;
    logic       clk25MHz = 1'b0;
    logic       reset_n;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       btn_up, btn_down, btn_left, btn_right, btn_start;

    int n_checks = 0;
    int n_fail   = 0;
    int mv, len_exp, hx;

    always #20 clk25MHz = ~clk25MHz;

    snake_engine_if #(.MAX_LEN(16)) ia ();
    snake_engine_if #(.MAX_LEN(16)) ib ();

    assign ia.pixel_x = pixel_x;   assign ib.pixel_x = pixel_x;
    assign ia.pixel_y = pixel_y;   assign ib.pixel_y = pixel_y;
    assign ia.btn_up = btn_up;     assign ib.btn_up = btn_up;
    assign ia.btn_down = btn_down; assign ib.btn_down = btn_down;
    assign ia.btn_left = btn_left; assign ib.btn_left = btn_left;
    assign ia.btn_right = btn_right; assign ib.btn_right = btn_right;
    assign ia.btn_start = btn_start; assign ib.btn_start = btn_start;

    snake_engine #(.MAX_LEN(16), .MOVE_DIV(4), .GROW_EVERY(8)) dut_a (
        .clk25MHz (clk25MHz),
        .reset_n  (reset_n),
        .bus      (ia.slave)
    );

    snake_engine #(.MAX_LEN(16), .MOVE_DIV(4), .GROW_EVERY(2)) dut_b (
        .clk25MHz (clk25MHz),
        .reset_n  (reset_n),
        .bus      (ib.slave)
    );

    task automatic tick();
        @(posedge clk25MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_pix(input string tag, input bit sel_b, input int px, input int py, input bit exp);
        pixel_x = 10'(px);
        pixel_y = 10'(py);
        tick();
        chk(tag, sel_b ? {31'd0, ib.Snake} : {31'd0, ia.Snake}, {31'd0, exp});
    endtask

    task automatic check_cell(input string tag, input bit sel_b, input int cx, input int cy, input bit exp);
        check_pix(tag, sel_b, cx * 16 + 8, cy * 16 + 8, exp);
    endtask

    // mask order: up, down, left, right, start
    task automatic pulse(input logic [4:0] m);
        {btn_up, btn_down, btn_left, btn_right, btn_start} = m;
        tick();
        {btn_up, btn_down, btn_left, btn_right, btn_start} = 5'b0;
    endtask

    // Five active-area cycles guarantee a pending move, then exactly one blanking cycle executes it.
    task automatic do_move();
        pixel_x = 10'd700;
        pixel_y = 10'd0;
        repeat (5) tick();
        pixel_y = 10'd480;
        tick();
        pixel_y = 10'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        {btn_up, btn_down, btn_left, btn_right, btn_start} = 5'b0;
        pixel_x = 10'd320;
        pixel_y = 10'd240;
        tick();
        tick();
        chk("rst_snake", {31'd0, ia.Snake}, 0);
        chk("rst_black", {31'd0, ia.Black}, 0);
        chk("rst_length", {27'd0, ia.length}, 4);
        reset_n = 1'b1;

        check_pix("t1_head", 0, 320, 240, 1);
        check_pix("t1_tail", 0, 272, 240, 1);
        check_pix("t1_behind", 0, 256, 240, 0);
        check_pix("t1_ahead", 0, 336, 240, 0);
        chk("t1_black", {31'd0, ia.Black}, 0);
        chk("t1_length", {27'd0, ia.length}, 4);

        pulse(5'b00010);
        pixel_x = 10'd336;
        pixel_y = 10'd240;
        repeat (6) tick();
        chk("t2_no_midframe_move", {31'd0, ia.Snake}, 0);
        pixel_y = 10'd480;
        tick();
        check_pix("t2_new_head", 0, 336, 240, 1);
        check_pix("t2_old_tail", 0, 272, 240, 0);
        check_cell("t2_tail", 0, 18, 15, 1);

        pulse(5'b00100);
        do_move();
        check_cell("t3_opp_ignored_head", 0, 22, 15, 1);
        check_cell("t3_opp_ignored_tail", 0, 18, 15, 0);
        pulse(5'b11000);
        do_move();
        check_cell("t3_up_head", 0, 22, 14, 1);
        check_cell("t3_not_down", 0, 22, 16, 0);
        check_cell("t3_not_right", 0, 23, 15, 0);
        chk("t3_length", {27'd0, ia.length}, 4);

        pulse(5'b10000);
        pulse(5'b00010);
        mv = 3;
        len_exp = 4;
        hx = 22;
        while (hx < 39) begin
            do_move();
            if ((mv % 8) == 7 && len_exp < 16) len_exp++;
            mv++;
            hx++;
        end
        check_cell("t4_at_wall", 0, 39, 14, 1);
        chk("t4_length_before", {27'd0, ia.length}, 32'(len_exp));
        chk("t4_black_before", {31'd0, ia.Black}, 0);
        do_move();
        chk("t4_black_rise", {31'd0, ia.Black}, 1);
        pixel_y = 10'd480;
        repeat (8) tick();
        chk("t4_black_hold", {31'd0, ia.Black}, 1);
        chk("t4_length_frozen", {27'd0, ia.length}, 32'(len_exp));
        check_cell("t4_head_frozen", 0, 39, 14, 1);
        check_cell("t4_tail_frozen", 0, 40 - len_exp, 14, 1);
        check_cell("t4_past_tail", 0, 39 - len_exp, 14, 0);
        pulse(5'b00001);
        chk("t4_black_fall", {31'd0, ia.Black}, 0);
        chk("t4_length_reinit", {27'd0, ia.length}, 4);
        check_cell("t4_init_head", 0, 20, 15, 1);
        check_cell("t4_init_tail", 0, 17, 15, 1);
        check_cell("t4_old_gone", 0, 39, 14, 0);

        pulse(5'b00010);
        pixel_x = 10'd328;
        pixel_y = 10'd248;
        repeat (6) tick();
        chk("t6_snake_pre", {31'd0, ia.Snake}, 1);
        #5 reset_n = 1'b0;
        #1;
        chk("t6_snake_async", {31'd0, ia.Snake}, 0);
        chk("t6_black_async", {31'd0, ia.Black}, 0);
        chk("t6_length_async", {27'd0, ia.length}, 4);
        tick();
        tick();
        reset_n = 1'b1;
        pixel_y = 10'd480;
        repeat (6) tick();
        check_cell("t6_head_stays", 0, 20, 15, 1);
        check_cell("t6_no_move", 0, 21, 15, 0);
        check_cell("t6_tail_stays", 0, 17, 15, 1);

        pulse(5'b00010);
        do_move();
        pulse(5'b10000);
        do_move();
        chk("t5_b_len5", {27'd0, ib.length}, 5);
        pulse(5'b00100);
        do_move();
        pulse(5'b01000);
        do_move();
        chk("t5_a_tail_chase_black", {31'd0, ia.Black}, 0);
        chk("t5_a_length", {27'd0, ia.length}, 4);
        check_cell("t5_a_head", 0, 20, 15, 1);
        check_cell("t5_a_vacated", 0, 19, 15, 0);
        chk("t5_b_self_black", {31'd0, ib.Black}, 1);
        chk("t5_b_len_frozen", {27'd0, ib.length}, 5);

        pulse(5'b00001);
        chk("t5_b_restart", {31'd0, ib.Black}, 0);
        check_cell("t5_a_start_ignored", 0, 21, 14, 1);
        pulse(5'b00010);
        do_move();
        do_move();
        chk("t5_b_len5_again", {27'd0, ib.length}, 5);
        do_move();
        do_move();
        chk("t5_b_len6", {27'd0, ib.length}, 6);
        check_cell("t5_b_head", 1, 24, 15, 1);
        check_cell("t5_b_tail", 1, 19, 15, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
